// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment driver: scans BCD digits onto shared active-low cathodes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above digit 0.
module seven_seg_scan #(
  parameter int NDIGIT         = 4,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NDIGIT*4-1:0]   BCD,
  input  logic [NDIGIT-1:0]     dp_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NDIGIT-1:0]     anode
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGIT - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [6:0]       SEG_DASH = 7'h3F;

  logic [CNT_W-1:0]    refresh_cnt;
  logic [IDX_W-1:0]    idx;
  logic [NDIGIT*4-1:0] snap_bcd;
  logic [NDIGIT-1:0]   snap_dp;
  logic [NDIGIT-1:0]   blank;
  logic [3:0]          cur_digit;
  logic                cur_dp;
  logic                cur_blank;
  logic                terminal;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = SEG_DASH;
    endcase
  endfunction

  assign terminal = (refresh_cnt == CNT_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it is zero; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = NDIGIT - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (snap_bcd[i*4 +: 4] == 4'd0);
      blank[i]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIGIT; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = snap_bcd[i*4 +: 4];
        cur_dp    = snap_dp[i];
        cur_blank = blank[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
      snap_bcd    <= '0;
      snap_dp     <= '0;
    end else if (!en) begin
      refresh_cnt <= '0;
      idx         <= '0;
      snap_bcd    <= BCD;
      snap_dp     <= dp_mask;
    end else if (terminal) begin
      refresh_cnt <= '0;
      if (idx == IDX_LAST) begin
        // Frame boundary: take a fresh coherent copy of the inputs.
        idx      <= '0;
        snap_bcd <= BCD;
        snap_dp  <= dp_mask;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode <= '1;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else if (!en) begin
      anode <= '1;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else begin
      anode <= ~(NDIGIT'(1) << idx);
      seg   <= cur_blank ? SEG_OFF : encode(cur_digit);
      dp    <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (NDIGIT=4, REFRESH_CYCLES=4): stimulus pushes expected
// display events, a negedge monitor pops one per output change and checks value and spacing.
module tb_seven_seg_scan;

  localparam int NDIGIT = 4;
  localparam int REFRESH_CYCLES = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZSEG = 7'h7F;
`else
  localparam logic [6:0] ZSEG = 7'h40;
`endif

  typedef struct {
    logic [NDIGIT-1:0] anode;
    logic [6:0]        seg;
    logic              dp;
    int                gap;   // cycles since previous event; 0 = not checked
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [NDIGIT*4-1:0] BCD;
  logic [NDIGIT-1:0]   dp_mask;
  logic [6:0]          seg;
  logic                dp;
  logic [NDIGIT-1:0]   anode;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   cyc          = 0;
  int   last_cyc     = 0;
  logic [11:0] prev  = {4'hF, 7'h7F, 1'b1};

  seven_seg_scan #(.NDIGIT(NDIGIT), .REFRESH_CYCLES(REFRESH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .BCD(BCD), .dp_mask(dp_mask),
    .seg(seg), .dp(dp), .anode(anode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int gap);
    exp_t e;
    e.anode = a; e.seg = s; e.dp = d; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: every change of {anode,seg,dp} is one display event.
  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t e;
    cyc++;
    cur = {anode, seg, dp};
    if (cur !== prev) begin
      prev = cur;
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_event at %0t: got %h, expected no change", $time, cur);
      end else begin
        e = sb_q.pop_front();
        check("display", 32'(cur), 32'({e.anode, e.seg, e.dp}));
        if (e.gap != 0) check("digit_period", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; BCD = '0; dp_mask = '0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_state", 32'({anode, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    @(posedge clk); #8 rst_n = 1'b1;

    // Basic scan of 1234, two frames
    wait_edges(1);
    BCD = 16'h1234;
    wait_edges(2);
    en = 1'b1;
    push(4'b1110, 7'h19, 1'b1, 0);
    push(4'b1101, 7'h30, 1'b1, 4);
    push(4'b1011, 7'h24, 1'b1, 4);
    push(4'b0111, 7'h79, 1'b1, 4);
    push(4'b1110, 7'h19, 1'b1, 4);
    push(4'b1101, 7'h30, 1'b1, 4);
    push(4'b1011, 7'h24, 1'b1, 4);
    push(4'b0111, 7'h79, 1'b1, 4);

    // Mid-frame change while digit 1 is lit only shows in the next frame
    wait_edges(21);
    BCD = 16'h5678;
    push(4'b1110, 7'h00, 1'b1, 4);
    push(4'b1101, 7'h78, 1'b1, 4);
    push(4'b1011, 7'h02, 1'b1, 4);
    push(4'b0111, 7'h12, 1'b1, 4);

    // Drop enable mid-frame, reload inputs, restore enable
    wait_edges(26);
    en = 1'b0; BCD = 16'h00A9; dp_mask = 4'b0010;
    push(4'b1111, 7'h7F, 1'b1, 3);
    wait_edges(3);
    en = 1'b1;
    push(4'b1110, 7'h10, 1'b1, 3);
    push(4'b1101, 7'h3F, 1'b0, 4);
    push(4'b1011, ZSEG,  1'b1, 4);
    push(4'b0111, ZSEG,  1'b1, 4);

    // All-zero value: digit 0 always shows
    wait_edges(7);
    BCD = 16'h0000; dp_mask = 4'b0000;
    push(4'b1110, 7'h40, 1'b1, 4);
    push(4'b1101, ZSEG,  1'b1, 4);
    push(4'b1011, ZSEG,  1'b1, 4);

    // Asynchronous reset between edges while digit 2 is lit
    wait_edges(19);
    rst_n = 1'b0;
    push(4'b1111, 7'h7F, 1'b1, 0);
    #1;
    check("async_reset_instant", 32'({anode, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    BCD = 16'h4321;
    wait_edges(2);
    rst_n = 1'b1;
    push(4'b1110, 7'h40, 1'b1, 3);
    push(4'b1101, ZSEG,  1'b1, 4);
    push(4'b1011, ZSEG,  1'b1, 4);
    push(4'b0111, ZSEG,  1'b1, 4);
    push(4'b1110, 7'h79, 1'b1, 4);

    wait_edges(20);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
